seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scan controller; next generation of the clock's display driver.

---
 rtl/seg_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Function : Multiplexed 7-segment scan controller. It skips masked digits,
//             blanks the start of each slot against ghosting and drives PWM
//             brightness. Optional blink feature: define SEG_SCAN_BLINK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 6,
   parameter int SEG_W        = 7,
   parameter int SCAN_DIV     = 5000,
   parameter int BLANK_CYC    = 64,
   parameter int BRIGHT_W     = 4
`ifdef SEG_SCAN_BLINK_EN
  ,parameter int BLINK_FRAMES = 50
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_DIGITS*SEG_W-1:0] i_seg,
   input  logic [NUM_DIGITS-1:0]       i_dp,
   input  logic [NUM_DIGITS-1:0]       i_digit_en,
   input  logic [BRIGHT_W-1:0]         i_bright,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [NUM_DIGITS-1:0]       i_blink_mask,
`endif
   output logic [NUM_DIGITS-1:0]       o_seg_enb,
   output logic [SEG_W-1:0]            o_seg,
   output logic                        o_seg_dp,
   output logic                        o_frame_start
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] C_SLOT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] C_BLANK_END = CNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
   logic                    valid_q, valid_d;
   logic [BRIGHT_W-1:0]     bright_q, bright_d;
   logic [SEG_W-1:0]        seg_lat_q, seg_lat_d;
   logic                    dp_lat_q, dp_lat_d;
   logic [NUM_DIGITS-1:0]   seg_enb_q, seg_enb_d;
   logic [SEG_W-1:0]        seg_out_q, seg_out_d;
   logic                    seg_dp_q, seg_dp_d;
   logic                    frame_q, frame_d;
   logic                    hide_d;

   logic                    w_boundary;
   logic                    w_found;
   logic [IDX_W-1:0]        w_idx_srch;
   logic                    w_lit;

   // Circular search for the first enabled digit after idx; the current
   // digit itself is the last candidate so a lone enabled digit is kept.
   always_comb begin
      w_found    = 1'b0;
      w_idx_srch = idx_q;
      for (int k = 1; k <= NUM_DIGITS; k++) begin
         int cand;
         cand = int'(idx_q) + k;
         if (cand >= NUM_DIGITS) cand = cand - NUM_DIGITS;
         if (!w_found && i_digit_en[IDX_W'(cand)]) begin
            w_found    = 1'b1;
            w_idx_srch = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      w_boundary = (slot_cnt_q == C_SLOT_LAST);
      slot_cnt_d = w_boundary ? '0 : slot_cnt_q + CNT_W'(1);

      if (w_boundary)
         state_d = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;
      else if (slot_cnt_d == C_BLANK_END)
         state_d = ST_ON;
      else
         state_d = state_q;

      pwm_d = (state_q == ST_ON && !w_boundary) ? pwm_q + BRIGHT_W'(1) : '0;

      valid_d   = valid_q;
      idx_d     = idx_q;
      bright_d  = bright_q;
      seg_lat_d = seg_lat_q;
      dp_lat_d  = dp_lat_q;
      frame_d   = 1'b0;
      // Everything a slot displays is frozen here for the whole slot.
      if (w_boundary) begin
         valid_d   = w_found;
         if (w_found) idx_d = w_idx_srch;
         bright_d  = i_bright;
         seg_lat_d = i_seg[int'(idx_d)*SEG_W +: SEG_W];
         dp_lat_d  = i_dp[idx_d];
         frame_d   = w_found && (w_idx_srch <= idx_q);
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int FC_W = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;

   logic            blink_q, blink_d;
   logic [FC_W-1:0] fcnt_q, fcnt_d;
   logic            hide_q;

   // fcnt holds the frames spent in the current blink phase; the phase flips
   // on the pulse that would start frame BLINK_FRAMES+1 of that phase.
   always_comb begin
      blink_d = blink_q;
      fcnt_d  = fcnt_q;
      if (frame_d) begin
         if (fcnt_q == FC_W'(BLINK_FRAMES)) begin
            blink_d = ~blink_q;
            fcnt_d  = FC_W'(1);
         end else begin
            fcnt_d  = fcnt_q + FC_W'(1);
         end
      end
      hide_d = w_boundary ? (blink_d & i_blink_mask[idx_d]) : hide_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_q <= 1'b0;
         fcnt_q  <= '0;
         hide_q  <= 1'b0;
      end else begin
         blink_q <= blink_d;
         fcnt_q  <= fcnt_d;
         hide_q  <= hide_d;
      end
   end
`else
   assign hide_d = 1'b0;
`endif

   // Outputs are computed from the next-cycle slot state so the pins change
   // on the same edge as the state they represent.
   always_comb begin
      w_lit = (state_d == ST_ON) && valid_d && !hide_d &&
              ((bright_d == '1) || (pwm_d < bright_d));
      seg_enb_d = w_lit ? ~(NUM_DIGITS'(1) << idx_d) : '1;
      seg_out_d = w_lit ? seg_lat_d : '0;
      seg_dp_d  = w_lit ? dp_lat_d : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BLANK;
         slot_cnt_q <= C_SLOT_LAST;
         idx_q      <= C_IDX_LAST;
         pwm_q      <= '0;
         valid_q    <= 1'b0;
         bright_q   <= '0;
         seg_lat_q  <= '0;
         dp_lat_q   <= 1'b0;
         seg_enb_q  <= '1;
         seg_out_q  <= '0;
         seg_dp_q   <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_cnt_q <= slot_cnt_d;
         idx_q      <= idx_d;
         pwm_q      <= pwm_d;
         valid_q    <= valid_d;
         bright_q   <= bright_d;
         seg_lat_q  <= seg_lat_d;
         dp_lat_q   <= dp_lat_d;
         seg_enb_q  <= seg_enb_d;
         seg_out_q  <= seg_out_d;
         seg_dp_q   <= seg_dp_d;
         frame_q    <= frame_d;
      end
   end

   assign o_seg_enb     = seg_enb_q;
   assign o_seg         = seg_out_q;
   assign o_seg_dp      = seg_dp_q;
   assign o_frame_start = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Function : Self-checking bench for seg_scan_ctrl: slot-level reference model
//             compared every cycle plus hand-computed pin checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

   localparam int ND = 6;
   localparam int SW = 7;
   localparam int SD = 16;
   localparam int BC = 4;
   localparam int BW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [ND*SW-1:0] seg_in;
   logic [ND-1:0]   dp_in, en_in, mask_in;
   logic [BW-1:0]   bright_in;
   logic [ND-1:0]   enb;
   logic [SW-1:0]   seg;
   logic            dp, fs;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .NUM_DIGITS(ND), .SEG_W(SW), .SCAN_DIV(SD), .BLANK_CYC(BC), .BRIGHT_W(BW)
`ifdef SEG_SCAN_BLINK_EN
     ,.BLINK_FRAMES(2)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_seg(seg_in),
      .i_dp(dp_in),
      .i_digit_en(en_in),
      .i_bright(bright_in),
`ifdef SEG_SCAN_BLINK_EN
      .i_blink_mask(mask_in),
`endif
      .o_seg_enb(enb),
      .o_seg(seg),
      .o_seg_dp(dp),
      .o_frame_start(fs)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // Slot-level model: position in a 16-cycle slot, first BC cycles dark,
   // PWM phase is simply the ON-cycle ordinal modulo 2^BW.
   bit            model_ok = 0;
   int            mpos, mdig, mframes, nd;
   bit            mvalid, mhide, lit;
   logic [BW-1:0] mbright;
   logic [SW-1:0] mseg;
   logic          mdp;
   logic [ND-1:0] e_enb;
   logic [SW-1:0] e_seg;
   logic          e_dp, e_fs;

   always @(posedge clk) begin
      model_ok = 1;
      if (rst) begin
         cyc = 0; mpos = SD - 1; mdig = ND - 1; mvalid = 0; mhide = 0; mframes = 0;
         e_enb = '1; e_seg = '0; e_dp = 0; e_fs = 0;
      end else begin
         cyc++;
         mpos = (mpos + 1) % SD;
         e_fs = 0;
         if (mpos == 0) begin
            nd = -1;
            for (int k = 1; k <= ND; k++)
               if (nd < 0 && en_in[(mdig + k) % ND]) nd = (mdig + k) % ND;
            mvalid = (nd >= 0);
            if (mvalid) begin
               e_fs = (nd <= mdig);
               mdig = nd;
               if (e_fs) mframes++;
            end
            mbright = bright_in;
            mseg    = seg_in[mdig*SW +: SW];
            mdp     = dp_in[mdig];
            mhide   = 0;
`ifdef SEG_SCAN_BLINK_EN
            mhide   = mask_in[mdig] && (mframes >= 1) && ((((mframes - 1) / 2) % 2) == 1);
`endif
         end
         lit   = (mpos >= BC) && mvalid && !mhide &&
                 ((mbright == 2'b11) || (((mpos - BC) % 4) < int'(mbright)));
         e_enb = lit ? ~(6'b000001 << mdig) : 6'h3F;
         e_seg = lit ? mseg : '0;
         e_dp  = lit ? mdp : 1'b0;
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("model_enb", enb, e_enb);
         chk("model_seg", seg, e_seg);
         chk("model_dp", dp, e_dp);
         chk("model_frame", fs, e_fs);
      end
   end

   task automatic wait_cyc(input int n);
      int guard;
      guard = 0;
      while (cyc != n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != n) chk("wait_cyc", cyc, n);
   endtask

   initial begin
      en_in = 6'h3F; bright_in = 2'd3; dp_in = 6'b000101; mask_in = '0;
      for (int k = 0; k < ND; k++) seg_in[k*SW +: SW] = SW'(k + 1);
      repeat (3) @(negedge clk);
      chk("rst_enb", enb, 6'h3F);
      chk("rst_seg", seg, 0);
      chk("rst_dp", dp, 0);
      chk("rst_fs", fs, 0);
      rst = 1'b0;

      // Basic scan, all digits enabled, full brightness
      wait_cyc(1);   chk("t1_fs_c1", fs, 1);
      wait_cyc(4);   chk("t1_blank_c4", enb, 6'h3F);
      wait_cyc(5);   chk("t1_enb_c5", enb, 6'b111110);
                     chk("t1_seg_c5", seg, 7'd1);
                     chk("t1_dp_c5", dp, 1);
      wait_cyc(21);  chk("t1_enb_c21", enb, 6'b111101);
                     chk("t1_seg_c21", seg, 7'd2);
      wait_cyc(96);  chk("t1_fs_c96", fs, 0);
      wait_cyc(97);  chk("t1_fs_c97", fs, 1);

      // Sparse mask: digits 1 and 3 alternate
      wait_cyc(200); en_in = 6'b001010;
      wait_cyc(213); chk("t2_enb_d1", enb, 6'b111101);
      wait_cyc(229); chk("t2_enb_d3", enb, 6'b110111);
      wait_cyc(241); chk("t2_fs_c241", fs, 1);
      wait_cyc(257); chk("t2_fs_c257", fs, 0);
      wait_cyc(273); chk("t2_fs_c273", fs, 1);

      // PWM: brightness 1 lights pwm phase 0 only; brightness 0 is dark
      wait_cyc(280); bright_in = 2'd1;
      wait_cyc(293); chk("t3_pwm_lit0", enb, 6'b110111);
      wait_cyc(294); chk("t3_pwm_off1", enb, 6'h3F);
      wait_cyc(297); chk("t3_pwm_lit4", enb, 6'b110111);
      wait_cyc(300); bright_in = 2'd0;
      wait_cyc(305); chk("t3_fs_c305", fs, 1);
      wait_cyc(309); chk("t3_dark_c309", enb, 6'h3F);
      wait_cyc(312); chk("t3_dark_c312", enb, 6'h3F);

      // Empty mask for three slots, then only digit 0
      wait_cyc(315); en_in = 6'h00; bright_in = 2'd3;
      wait_cyc(325); chk("t4_empty_enb", enb, 6'h3F);
      wait_cyc(337); chk("t4_empty_fs1", fs, 0);
      wait_cyc(353); chk("t4_empty_fs2", fs, 0);
      wait_cyc(360); en_in = 6'h01;
      wait_cyc(369); chk("t4_resume_fs", fs, 1);
      wait_cyc(373); chk("t4_resume_enb", enb, 6'b111110);
      wait_cyc(385); chk("t4_single_fs", fs, 1);

      // Reset in the middle of the digit-3 slot
      wait_cyc(390); en_in = 6'h3F;
      wait_cyc(442); chk("t5_pre_rst_enb", enb, 6'b110111);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_enb", enb, 6'h3F);
      chk("t5_rst_seg", seg, 0);
      chk("t5_rst_fs", fs, 0);
      mask_in = 6'h01;
      rst = 1'b0;
      wait_cyc(1);   chk("t5_fs_c1", fs, 1);
      wait_cyc(5);   chk("t5_enb_c5", enb, 6'b111110);
      wait_cyc(21);  chk("t5_enb_c21", enb, 6'b111101);
      wait_cyc(101); chk("t6_frame2_d0", enb, 6'b111110);
`ifdef SEG_SCAN_BLINK_EN
      wait_cyc(197); chk("t6_frame3_d0", enb, 6'h3F);
      wait_cyc(213); chk("t6_frame3_d1", enb, 6'b111101);
      wait_cyc(293); chk("t6_frame4_d0", enb, 6'h3F);
      wait_cyc(389); chk("t6_frame5_d0", enb, 6'b111110);
`else
      wait_cyc(197); chk("t6_frame3_d0", enb, 6'b111110);
      wait_cyc(389); chk("t6_frame5_d0", enb, 6'b111110);
`endif
      wait_cyc(500);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
